axi_lite_slave_mmap_4x32x32_r4: RTL and testbench
=================================================

Name: axi_lite_slave_mmap_4x32x32_r4

Overview:
AXI4-Lite slave exposing four 32-bit read/write registers, memory-mapped at 0x10000 + n*0x4000. Byte-granular writes use WSTRB. It sits on the SoC control bus as a simple CSR block. This variant uses 4 registers, 32-bit data and 32-bit address.

Parameters:
NUM_REGS, 4, number of registers (index width = log2(NUM_REGS))
C_S_AXI_DATA_WIDTH, 32, data width (WSTRB width = C_S_AXI_DATA_WIDTH/8)
C_S_AXI_ADDR_WIDTH, 32, address width
BASE_ADDR, 0x10000, start of the register window
REG_STRIDE, 0x4000, address spacing between registers (window = NUM_REGS*REG_STRIDE = 0x10000)

Ports:
clock  in  1  single clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
S_AXI_AWADDR  in  32  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte lane enables
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  32  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready

Behaviour:
- Reset (async, active-high): all registers 0; AWREADY, WREADY, BVALID, ARREADY, RVALID = 0; BRESP, RRESP, RDATA = 0. Reset mid-transaction aborts it; no response is issued afterwards.
- Decode: in range iff BASE_ADDR <= addr < BASE_ADDR+0x10000. Register index = addr[15:14]. Lower 14 bits are don't-care.
- Write accept: AWREADY and WREADY are registered and rise together for exactly one cycle. They rise when AWVALID && WVALID && !AWREADY && !BVALID. AW-only or W-only is not accepted; the slave waits for both.
- Write commit: on the edge where AWVALID&AWREADY&WVALID&WREADY, each byte lane i with WSTRB[i]=1 is updated; lanes with WSTRB[i]=0 keep their value. WSTRB=0 writes nothing but still responds.
- Write response: BVALID is set on the commit edge and held until the edge with BVALID&&BREADY. BRESP=00 in range; 11 (DECERR) out of range, with no register change.
- Only one write is outstanding. A master holding AWVALID/WVALID high for an extra cycle after the handshake must not cause a second write, because the !AWREADY/!BVALID gating blocks it.
- Read accept: ARREADY is registered and pulses one cycle when ARVALID && !ARREADY && !RVALID.
- Read data: on the edge where ARVALID&ARREADY, RDATA is loaded from the selected register and RVALID=1. Both are held stable until RVALID&&RREADY. RRESP=00 in range; out of range gives RDATA=0, RRESP=11.
- Latency: valid to ready is 1 cycle; ready to BVALID/RVALID is 1 cycle.
- Read and write channels are independent. A read and a write to the same register on the same edge returns the pre-write value.

Decomposition:
- Package axi_lite_mmap_pkg: RESP_OKAY=2'b00, RESP_DECERR=2'b11, BASE_ADDR, REG_STRIDE, NUM_REGS, and the register-index type.
- One natural sub-module, axi_lite_mmap_regfile: a byte-strobed register bank with write port (en, idx, data, strb), combinational read by index, and async reset to 0.
- Handshake FSM logic lives in the top level.

Test Plan:
- Post-reset reads of 0x10000/0x14000/0x18000/0x1C000 -> 0x00000000, RRESP=00.
- Write 0xDEADBEEF/0x12345678/0xABCDEF01/0x87654321 with strb F to the four registers -> readback matches, BRESP=00.
- After the previous step, apply these strobed writes, then read back all four registers:
  - 0x000000FF strb1 to 0x10000 -> 0xDEADBEFF
  - 0xAA000000 strb8 to 0x14000 -> 0xAA345678
  - 0x0000FFFF strb6 to 0x18000 -> 0xAB00FF01
  - 0xFFFFFFFF strb0 to 0x1C000 -> 0x87654321 unchanged
- Assert reset mid-operation after writes -> all four registers read 0; BVALID/RVALID low during reset.
- Patterns 0xAAAAAAAA, 0x55555555, 0xFFFFFFFF, 0x00000000 to regs 0..3; hold VALID one cycle past the handshake -> exactly one write and one BVALID per transaction; readback matches.
- Write/read 0x20000 -> BRESP=11, RRESP=11, RDATA=0, registers unchanged.

Source files
------------

// File: rtl/axi_lite_mmap_pkg.sv
// Shared constants and types for the AXI4-Lite memory-mapped CSR block.
// Holds the address map (base, stride, register count), bus widths,
// response codes, the register-index type and the handshake state encodings.
package axi_lite_mmap_pkg;

  localparam int unsigned NUM_REGS           = 4;
  localparam int unsigned C_S_AXI_DATA_WIDTH = 32;
  localparam int unsigned C_S_AXI_ADDR_WIDTH = 32;

  localparam int unsigned IDX_W        = $clog2(NUM_REGS);
  localparam int unsigned DATA_W       = C_S_AXI_DATA_WIDTH;
  localparam int unsigned ADDR_W       = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned STRB_W       = DATA_W / 8;

  localparam int unsigned BASE_ADDR    = 32'h0001_0000;
  localparam int unsigned REG_STRIDE   = 32'h0000_4000;
  localparam int unsigned WINDOW       = NUM_REGS * REG_STRIDE;
  localparam int unsigned STRIDE_SHIFT = $clog2(REG_STRIDE);

  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [1:0] RESP_DECERR   = 2'b11;

  typedef logic [IDX_W-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_ACCEPT = 2'd1,
    W_RESP   = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_ACCEPT = 2'd1,
    R_DATA   = 2'd2
  } rd_state_e;

endpackage

// File: rtl/axi_lite_mmap_regfile.sv
// Byte-strobed register bank with one write port and one combinational read port.
// Ports:
//   clock, reset      : rising-edge clock, asynchronous active-high reset (clears all regs)
//   wr_en             : commit the write this edge
//   wr_idx/wr_data    : target register and data
//   wr_strb           : per-byte lane enables; disabled lanes keep their value
//   rd_idx            : read select
//   rd_data_c         : combinational read of the current (pre-write) register value
module axi_lite_mmap_regfile
  import axi_lite_mmap_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  reg_idx_t          wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [STRB_W-1:0] wr_strb,
  input  reg_idx_t          rd_idx,
  output logic [DATA_W-1:0] rd_data_c
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  // Merge enabled byte lanes into the selected register.
  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (wr_strb[b]) begin
          regs_d[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Reads see the registered value, so a same-edge write is not visible yet.
  assign rd_data_c = regs_q[rd_idx];

endmodule

// File: rtl/axi_lite_slave_mmap_4x32x32_r4.sv
// AXI4-Lite slave exposing four 32-bit CSRs at BASE_ADDR + n*REG_STRIDE.
// Ports:
//   clock, reset                 : rising-edge clock, asynchronous active-high reset
//   S_AXI_AW*/S_AXI_W*/S_AXI_B*  : write address, write data, write response channels
//   S_AXI_AR*/S_AXI_R*           : read address and read data channels
//   S_AXI_AWPROT/S_AXI_ARPROT    : accepted but ignored
// Write and read channels run independent handshake FSMs; every bus output is a flop.
module axi_lite_slave_mmap_4x32x32_r4
  import axi_lite_mmap_pkg::*;
(
  input  logic                          clock,
  input  logic                          reset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [2:0]                    S_AXI_AWPROT,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [2:0]                    S_AXI_ARPROT,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY
);

  wr_state_e         wr_state_q, wr_state_d;
  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;

  rd_state_e         rd_state_q, rd_state_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [ADDR_W-1:0] aw_off_c, ar_off_c;
  logic              aw_in_range_c, ar_in_range_c;
  reg_idx_t          aw_idx_c, ar_idx_c;
  logic              wr_hs_c, rd_hs_c;
  logic              wr_en_c;
  logic [DATA_W-1:0] rd_data_c;
  logic              unused_prot_c;

  assign unused_prot_c = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  // Address decode: the offset compare also rejects addresses below the base
  // because the subtraction wraps to a large value there.
  always_comb begin
    aw_off_c      = S_AXI_AWADDR - ADDR_W'(BASE_ADDR);
    ar_off_c      = S_AXI_ARADDR - ADDR_W'(BASE_ADDR);
    aw_in_range_c = (S_AXI_AWADDR >= ADDR_W'(BASE_ADDR)) && (aw_off_c < ADDR_W'(WINDOW));
    ar_in_range_c = (S_AXI_ARADDR >= ADDR_W'(BASE_ADDR)) && (ar_off_c < ADDR_W'(WINDOW));
    aw_idx_c      = IDX_W'(aw_off_c >> STRIDE_SHIFT);
    ar_idx_c      = IDX_W'(ar_off_c >> STRIDE_SHIFT);
  end

  assign wr_hs_c = awready_q && S_AXI_AWVALID && wready_q && S_AXI_WVALID;
  assign rd_hs_c = arready_q && S_AXI_ARVALID;
  assign wr_en_c = wr_hs_c && aw_in_range_c;

  axi_lite_mmap_regfile u_regfile (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (wr_en_c),
    .wr_idx    (aw_idx_c),
    .wr_data   (S_AXI_WDATA),
    .wr_strb   (S_AXI_WSTRB),
    .rd_idx    (ar_idx_c),
    .rd_data_c (rd_data_c)
  );

  // Write channel: accept only when address and data are both present,
  // then hold the response until the master takes it.
  always_comb begin
    wr_state_d = wr_state_q;
    awready_d  = 1'b0;
    wready_d   = 1'b0;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    case (wr_state_q)
      W_IDLE: begin
        if (S_AXI_AWVALID && S_AXI_WVALID && !awready_q && !bvalid_q) begin
          awready_d  = 1'b1;
          wready_d   = 1'b1;
          wr_state_d = W_ACCEPT;
        end
      end
      W_ACCEPT: begin
        if (wr_hs_c) begin
          bvalid_d   = 1'b1;
          bresp_d    = aw_in_range_c ? RESP_OKAY : RESP_DECERR;
          wr_state_d = W_RESP;
        end else begin
          // Master withdrew its request; drop back without responding.
          wr_state_d = W_IDLE;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_d   = 1'b0;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Read channel: data is captured at the address handshake and held until taken.
  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = 1'b0;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;
    case (rd_state_q)
      R_IDLE: begin
        if (S_AXI_ARVALID && !arready_q && !rvalid_q) begin
          arready_d  = 1'b1;
          rd_state_d = R_ACCEPT;
        end
      end
      R_ACCEPT: begin
        if (rd_hs_c) begin
          rvalid_d   = 1'b1;
          rresp_d    = ar_in_range_c ? RESP_OKAY : RESP_DECERR;
          rdata_d    = ar_in_range_c ? rd_data_c : '0;
          rd_state_d = R_DATA;
        end else begin
          rd_state_d = R_IDLE;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          rvalid_d   = 1'b0;
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= 2'b00;
      rdata_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;

endmodule

// File: tb/tb_axi_lite_slave_mmap_4x32x32_r4.sv
// Directed bench for the AXI4-Lite CSR slave: reset state, full and strobed
// writes, mid-transaction reset, held-valid single-accept, decode errors and
// same-edge read/write ordering.
module tb_axi_lite_slave_mmap_4x32x32_r4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [31:0] araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;

  int checks = 0;
  int errors = 0;
  int aw_hs_cnt = 0;
  int w_hs_cnt  = 0;
  int b_hs_cnt  = 0;
  int ar_hs_cnt = 0;

  axi_lite_slave_mmap_4x32x32_r4 dut (
    .clock         (clock),
    .reset         (reset),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready)
  );

  always #5 clock = ~clock;

  // Handshake counters, sampled mid-cycle; each counts the handshake due at the next rising edge.
  always @(negedge clock) begin
    if (!reset) begin
      if (awvalid && awready) aw_hs_cnt <= aw_hs_cnt + 1;
      if (wvalid && wready)   w_hs_cnt  <= w_hs_cnt + 1;
      if (bvalid && bready)   b_hs_cnt  <= b_hs_cnt + 1;
      if (arvalid && arready) ar_hs_cnt <= ar_hs_cnt + 1;
    end
  end

  // Bus master write; resp is X if the slave never handshakes.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input bit hold_extra,
                           output logic [1:0] resp);
    int n;
    @(posedge clock); #1;
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (awready !== 1'b1 && n < 20) begin @(posedge clock); #1; n++; end
    if (awready !== 1'b1) begin
      awvalid = 1'b0; wvalid = 1'b0; resp = 'x;
      $display("axi_write: no AWREADY for addr %h", addr);
      return;
    end
    @(posedge clock); #1;
    if (hold_extra) begin @(posedge clock); #1; end
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (bvalid !== 1'b1 && n < 20) begin @(posedge clock); #1; n++; end
    if (bvalid !== 1'b1) begin
      resp = 'x;
      $display("axi_write: no BVALID for addr %h", addr);
      return;
    end
    resp = bresp;
    bready = 1'b1;
    @(posedge clock); #1;
    bready = 1'b0;
  endtask

  // Bus master read; data/resp are X if the slave never handshakes.
  task automatic axi_read(input logic [31:0] addr, input bit hold_extra,
                          output logic [31:0] data, output logic [1:0] resp);
    int n;
    @(posedge clock); #1;
    araddr = addr; arvalid = 1'b1;
    n = 0;
    while (arready !== 1'b1 && n < 20) begin @(posedge clock); #1; n++; end
    if (arready !== 1'b1) begin
      arvalid = 1'b0; data = 'x; resp = 'x;
      $display("axi_read: no ARREADY for addr %h", addr);
      return;
    end
    @(posedge clock); #1;
    if (hold_extra) begin @(posedge clock); #1; end
    arvalid = 1'b0;
    n = 0;
    while (rvalid !== 1'b1 && n < 20) begin @(posedge clock); #1; n++; end
    if (rvalid !== 1'b1) begin
      data = 'x; resp = 'x;
      $display("axi_read: no RVALID for addr %h", addr);
      return;
    end
    data = rdata; resp = rresp;
    rready = 1'b1;
    @(posedge clock); #1;
    rready = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    logic [1:0]  r;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ready_valid: got %b expected 00000", {awready, wready, bvalid, arready, rvalid});
    end
    checks++;
    if ({bresp, rresp} !== 4'b0) begin
      errors++;
      $display("FAIL reset_resp: got bresp=%b rresp=%b expected 00/00", bresp, rresp);
    end
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h expected 00000000", rdata);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      axi_read(32'h0001_0000 + 32'(i) * 32'h4000, 1'b0, d, r);
      checks++;
      if (d !== 32'h0 || r !== 2'b00) begin
        errors++;
        $display("FAIL reset_read_reg%0d: got data=%h resp=%b expected 00000000/00", i, d, r);
      end
    end
  endtask

  task automatic test_full_write;
    logic [31:0] vals [4];
    logic [31:0] d;
    logic [1:0]  r;
    vals[0] = 32'hDEAD_BEEF; vals[1] = 32'h1234_5678;
    vals[2] = 32'hABCD_EF01; vals[3] = 32'h8765_4321;
    for (int i = 0; i < 4; i++) begin
      axi_write(32'h0001_0000 + 32'(i) * 32'h4000, vals[i], 4'hF, 1'b0, r);
      checks++;
      if (r !== 2'b00) begin
        errors++;
        $display("FAIL full_write_bresp_reg%0d: got %b expected 00", i, r);
      end
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(32'h0001_0000 + 32'(i) * 32'h4000, 1'b0, d, r);
      checks++;
      if (d !== vals[i] || r !== 2'b00) begin
        errors++;
        $display("FAIL full_write_read_reg%0d: got %h/%b expected %h/00", i, d, r, vals[i]);
      end
    end
  endtask

  task automatic test_strobe;
    logic [31:0] wd [4];
    logic [3:0]  st [4];
    logic [31:0] exp [4];
    logic [31:0] d;
    logic [1:0]  r;
    wd[0] = 32'h0000_00FF; st[0] = 4'h1; exp[0] = 32'hDEAD_BEFF;
    wd[1] = 32'hAA00_0000; st[1] = 4'h8; exp[1] = 32'hAA34_5678;
    wd[2] = 32'h0000_FFFF; st[2] = 4'h6; exp[2] = 32'hAB00_FF01;
    wd[3] = 32'hFFFF_FFFF; st[3] = 4'h0; exp[3] = 32'h8765_4321;
    for (int i = 0; i < 4; i++) begin
      axi_write(32'h0001_0000 + 32'(i) * 32'h4000, wd[i], st[i], 1'b0, r);
      checks++;
      if (r !== 2'b00) begin
        errors++;
        $display("FAIL strobe_bresp_reg%0d: got %b expected 00", i, r);
      end
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(32'h0001_0000 + 32'(i) * 32'h4000, 1'b0, d, r);
      checks++;
      if (d !== exp[i] || r !== 2'b00) begin
        errors++;
        $display("FAIL strobe_read_reg%0d: got %h/%b expected %h/00", i, d, r, exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    logic [1:0]  r;
    int n;
    bit stray;
    // Launch a write and a read together, then reset while both responses are pending.
    @(posedge clock); #1;
    awaddr = 32'h0001_4000; wdata = 32'h5A5A_5A5A; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h0001_0000; arvalid = 1'b1;
    n = 0;
    while (awready !== 1'b1 && n < 20) begin @(posedge clock); #1; n++; end
    @(posedge clock); #1;
    checks++;
    if (bvalid !== 1'b1 || rvalid !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pending: got bvalid=%b rvalid=%b expected 1/1", bvalid, rvalid);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bvalid !== 1'b0 || rvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async: got bvalid=%b rvalid=%b expected 0/0", bvalid, rvalid);
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (bvalid !== 1'b0 || rvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_held: got bvalid=%b rvalid=%b expected 0/0", bvalid, rvalid);
    end
    reset = 1'b0;
    stray = 1'b0;
    repeat (4) begin
      @(posedge clock); #1;
      if (bvalid !== 1'b0 || rvalid !== 1'b0) stray = 1'b1;
    end
    checks++;
    if (stray) begin
      errors++;
      $display("FAIL reset_mid_no_resp: got a response after reset expected none");
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(32'h0001_0000 + 32'(i) * 32'h4000, 1'b0, d, r);
      checks++;
      if (d !== 32'h0 || r !== 2'b00) begin
        errors++;
        $display("FAIL reset_mid_read_reg%0d: got %h/%b expected 00000000/00", i, d, r);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] pat [4];
    logic [31:0] d;
    logic [1:0]  r;
    int aw0, w0, b0, ar0;
    pat[0] = 32'hAAAA_AAAA; pat[1] = 32'h5555_5555;
    pat[2] = 32'hFFFF_FFFF; pat[3] = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      aw0 = aw_hs_cnt; w0 = w_hs_cnt; b0 = b_hs_cnt;
      axi_write(32'h0001_0000 + 32'(i) * 32'h4000, pat[i], 4'hF, 1'b1, r);
      @(posedge clock); #1;
      checks++;
      if (r !== 2'b00) begin
        errors++;
        $display("FAIL b2b_bresp_reg%0d: got %b expected 00", i, r);
      end
      checks++;
      if (aw_hs_cnt - aw0 != 1 || w_hs_cnt - w0 != 1 || b_hs_cnt - b0 != 1) begin
        errors++;
        $display("FAIL b2b_single_write_reg%0d: got aw=%0d w=%0d b=%0d expected 1/1/1",
                 i, aw_hs_cnt - aw0, w_hs_cnt - w0, b_hs_cnt - b0);
      end
    end
    for (int i = 0; i < 4; i++) begin
      ar0 = ar_hs_cnt;
      axi_read(32'h0001_0000 + 32'(i) * 32'h4000, 1'b1, d, r);
      @(posedge clock); #1;
      checks++;
      if (d !== pat[i] || r !== 2'b00) begin
        errors++;
        $display("FAIL b2b_read_reg%0d: got %h/%b expected %h/00", i, d, r, pat[i]);
      end
      checks++;
      if (ar_hs_cnt - ar0 != 1) begin
        errors++;
        $display("FAIL b2b_single_read_reg%0d: got %0d handshakes expected 1", i, ar_hs_cnt - ar0);
      end
    end
  endtask

  task automatic test_decerr;
    logic [31:0] pat [4];
    logic [31:0] d;
    logic [1:0]  r;
    pat[0] = 32'hAAAA_AAAA; pat[1] = 32'h5555_5555;
    pat[2] = 32'hFFFF_FFFF; pat[3] = 32'h0000_0000;
    axi_write(32'h0002_0000, 32'hCAFE_F00D, 4'hF, 1'b0, r);
    checks++;
    if (r !== 2'b11) begin
      errors++;
      $display("FAIL decerr_bresp: got %b expected 11", r);
    end
    axi_write(32'h0000_FFFC, 32'h1357_9BDF, 4'hF, 1'b0, r);
    checks++;
    if (r !== 2'b11) begin
      errors++;
      $display("FAIL decerr_below_base_bresp: got %b expected 11", r);
    end
    axi_read(32'h0002_0000, 1'b0, d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b11) begin
      errors++;
      $display("FAIL decerr_read_20000: got %h/%b expected 00000000/11", d, r);
    end
    axi_read(32'h0000_FFFC, 1'b0, d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b11) begin
      errors++;
      $display("FAIL decerr_read_below_base: got %h/%b expected 00000000/11", d, r);
    end
    axi_read(32'h0001_BFFC, 1'b0, d, r);
    checks++;
    if (d !== 32'hFFFF_FFFF || r !== 2'b00) begin
      errors++;
      $display("FAIL decode_low_bits_dontcare: got %h/%b expected ffffffff/00", d, r);
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(32'h0001_0000 + 32'(i) * 32'h4000, 1'b0, d, r);
      checks++;
      if (d !== pat[i] || r !== 2'b00) begin
        errors++;
        $display("FAIL decerr_unchanged_reg%0d: got %h/%b expected %h/00", i, d, r, pat[i]);
      end
    end
  endtask

  task automatic test_same_edge_rw;
    logic [31:0] d;
    logic [1:0]  r, br;
    fork
      axi_write(32'h0001_0000, 32'h1122_3344, 4'hF, 1'b0, br);
      axi_read(32'h0001_0000, 1'b0, d, r);
    join
    checks++;
    if (d !== 32'hAAAA_AAAA || r !== 2'b00 || br !== 2'b00) begin
      errors++;
      $display("FAIL same_edge_pre_write: got %h/%b bresp=%b expected aaaaaaaa/00 bresp=00", d, r, br);
    end
    axi_read(32'h0001_0000, 1'b0, d, r);
    checks++;
    if (d !== 32'h1122_3344 || r !== 2'b00) begin
      errors++;
      $display("FAIL same_edge_post_write: got %h/%b expected 11223344/00", d, r);
    end
  endtask

  initial begin
    test_reset();
    test_full_write();
    test_strobe();
    test_reset_mid();
    test_back_to_back();
    test_decerr();
    test_same_edge_rw();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
